// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for a 640x480 @ 60 Hz display path.
//   It scans DrawX/DrawY over the whole raster, including porches and sync.
//   It decodes the display-enable flag (blank) and the raw sync pulses.
//   The syncs pass through a SYNC_DELAY-deep register chain so that they
//   line up with the renderers' registered colour outputs.
//   It also keeps a frame-start strobe and a 16-bit frame counter.
//
// Ports
//   vga_clk      in   pixel clock (single clock domain)
//   reset_n      in   synchronous, active-low reset
//   DrawX        out  [9:0] horizontal position, 0..H_TOTAL-1
//   DrawY        out  [9:0] vertical position, 0..V_TOTAL-1
//   blank        out  1 = visible pixel, 0 = porch or sync
//   hs, vs       out  active-low syncs, delayed by SYNC_DELAY cycles
//   frame_start  out  one-cycle pulse when the counters wrap to (0,0)
//   frame_count  out  [15:0] frames completed since reset (wraps)
module vga_timing_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Decode boundaries are 11 bits wide.
  // A sync end can equal 1024 when the back porch is zero.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_VIS);
  localparam logic [10:0] V_VIS_END    = 11'(V_VIS);
  localparam logic [10:0] H_SYNC_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VIS + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
  end

  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic        frame_start_reg;
  logic [15:0] frame_count_reg;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        x_last;
  logic        y_last;
  logic        hs_raw;
  logic        vs_raw;

  assign x_ext  = {1'b0, x_reg};
  assign y_ext  = {1'b0, y_reg};
  assign x_last = (x_ext == H_LAST);
  assign y_last = (y_ext == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_reg           <= '0;
      y_reg           <= '0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      if (x_last) begin
        x_reg <= '0;
        if (y_last) begin
          y_reg           <= '0;
          frame_start_reg <= 1'b1;
          frame_count_reg <= frame_count_reg + 16'd1;
        end else begin
          y_reg <= y_reg + 10'd1;
        end
      end else begin
        x_reg <= x_reg + 10'd1;
      end
    end
  end

  assign DrawX       = x_reg;
  assign DrawY       = y_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

  assign blank  = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);

  // vsync depends on DrawY only.
  // DrawY changes only at the line wrap, so vsync switches at DrawX = 0.
  assign hs_raw = !((x_ext >= H_SYNC_START) && (x_ext < H_SYNC_END));
  assign vs_raw = !((y_ext >= V_SYNC_START) && (y_ext < V_SYNC_END));

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe_reg;
    logic [SYNC_DELAY-1:0] vs_pipe_reg;

    // Stage 0 takes the raw decode.
    // Each later stage copies its predecessor, so the last stage lags by SYNC_DELAY.
    always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
        hs_pipe_reg <= '1;
        vs_pipe_reg <= '1;
      end else begin
        hs_pipe_reg[0] <= hs_raw;
        vs_pipe_reg[0] <= vs_raw;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hs_pipe_reg[i] <= hs_pipe_reg[i-1];
          vs_pipe_reg[i] <= vs_pipe_reg[i-1];
        end
      end
    end

    assign hs = hs_pipe_reg[SYNC_DELAY-1];
    assign vs = vs_pipe_reg[SYNC_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench with three instances.
//   d_dut  uses the default 800x525 timing with SYNC_DELAY = 1.
//          It covers reset, blank, hsync and the line period.
//   z_dut  uses the default timing with SYNC_DELAY = 0.
//          It covers the undelayed hsync.
//   s_dut  uses a small 15x8 raster (120-cycle frame) with SYNC_DELAY = 1.
//          It covers vsync, the frame wrap, the blank count, mid-frame reset
//          and the frame_count wrap from 65535 to 0.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic [9:0]  d_x, d_y, z_x, z_y, s_x, s_y;
  logic        d_blank, d_hs, d_vs, d_fs;
  logic        z_blank, z_hs, z_vs, z_fs;
  logic        s_blank, s_hs, s_vs, s_fs;
  logic [15:0] d_fc, z_fc, s_fc;

  vga_timing_gen d_dut (
    .vga_clk(clk), .reset_n(rst_a), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) z_dut (
    .vga_clk(clk), .reset_n(rst_a), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
    .hs(z_hs), .vs(z_vs), .frame_start(z_fs), .frame_count(z_fc)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(1)
  ) s_dut (
    .vga_clk(clk), .reset_n(rst_b), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .frame_count(s_fc)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_d_to(input int x);
    int n = 0;
    while (d_x != 10'(x) && n < 2000) begin
      tick();
      n++;
    end
    check("reach_d_x", 32'(d_x), 32'(x));
  endtask

  task automatic run_s_to(input int x, input int y);
    int n = 0;
    while (!(s_x == 10'(x) && s_y == 10'(y)) && n < 500) begin
      tick();
      n++;
    end
    check("reach_s_x", 32'(s_x), 32'(x));
    check("reach_s_y", 32'(s_y), 32'(y));
  endtask

  initial begin
    int n_low, n_high, n;
    int nb, nv, nh, nf, first_v, last_v;
    logic blank_0_4;

    // Reset: hold reset low for 3 cycles.
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) tick();
    check("rst_x",  32'(d_x), 0);
    check("rst_y",  32'(d_y), 0);
    check("rst_blank", 32'(d_blank), 1);
    check("rst_hs", 32'(d_hs), 1);
    check("rst_vs", 32'(d_vs), 1);
    check("rst_fs", 32'(d_fs), 0);
    check("rst_fc", 32'(d_fc), 0);
    check("rst_z_hs", 32'(z_hs), 1);
    check("rst_s_vs", 32'(s_vs), 1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    check("first_edge_x", 32'(d_x), 1);
    check("first_edge_y", 32'(d_y), 0);
    check("first_edge_z_x", 32'(z_x), 1);

    // Blank boundary on line 0.
    run_d_to(639);
    check("blank_639_0", 32'(d_blank), 1);
    tick();
    check("blank_640_0", 32'(d_blank), 0);
    check("blank_640_y", 32'(d_y), 0);

    // hsync edges with SYNC_DELAY = 1 and SYNC_DELAY = 0.
    run_d_to(655);
    check("hs_d_at_655", 32'(d_hs), 1);
    check("hs_z_at_655", 32'(z_hs), 1);
    tick();
    check("hs_d_at_656", 32'(d_hs), 1);
    check("hs_z_at_656", 32'(z_hs), 0);
    tick();
    check("hs_d_at_657", 32'(d_hs), 0);

    n_low = 0;
    while (d_hs == 1'b0 && n_low < 200) begin
      n_low++;
      tick();
    end
    check("hs_low_width", 32'(n_low), 96);
    check("hs_rise_x", 32'(d_x), 753);
    check("hs_z_at_753", 32'(z_hs), 1);

    n_high = 0;
    while (d_hs == 1'b1 && n_high < 1000) begin
      n_high++;
      tick();
    end
    check("line_period", 32'(n_low + n_high), 800);
    check("line2_y", 32'(d_y), 1);
    check("line2_x", 32'(d_x), 657);

    // Small raster: fresh reset, then a mid-frame reset at (5,3).
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    check("s_first_x", 32'(s_x), 1);
    run_s_to(5, 3);
    check("s_mid_fc", 32'(s_fc), 0);
    rst_b = 1'b0;
    tick();
    check("mid_rst_x", 32'(s_x), 0);
    check("mid_rst_y", 32'(s_y), 0);
    check("mid_rst_fs", 32'(s_fs), 0);
    check("mid_rst_fc", 32'(s_fc), 0);
    check("mid_rst_hs", 32'(s_hs), 1);
    check("mid_rst_vs", 32'(s_vs), 1);
    rst_b = 1'b1;
    tick();
    check("mid_rel_x", 32'(s_x), 1);
    check("mid_rel_fs", 32'(s_fs), 0);

    // Frame wrap from (14,7) to (0,0).
    run_s_to(14, 7);
    check("blank_last_px", 32'(s_blank), 0);
    check("pre_wrap_fs", 32'(s_fs), 0);
    tick();
    check("wrap_x", 32'(s_x), 0);
    check("wrap_y", 32'(s_y), 0);
    check("wrap_fs", 32'(s_fs), 1);
    check("wrap_fc", 32'(s_fc), 1);

    // Count one full frame, starting at the wrap cycle.
    nb = 0; nv = 0; nh = 0; nf = 0; first_v = -1; last_v = -1; blank_0_4 = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (s_blank) nb++;
      if (!s_hs) nh++;
      if (s_fs) nf++;
      if (!s_vs) begin
        nv++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (i == 60) blank_0_4 = s_blank;
      tick();
    end
    check("blank_count", 32'(nb), 32);
    check("blank_0_vvis", 32'(blank_0_4), 0);
    check("hs_low_per_frame", 32'(nh), 24);
    check("vs_low_count", 32'(nv), 30);
    check("vs_fall_idx", 32'(first_v), 76);
    check("vs_last_idx", 32'(last_v), 105);
    check("fs_per_frame", 32'(nf), 1);
    check("fs_spacing", 32'(s_fs), 1);
    check("frame2_fc", 32'(s_fc), 2);

    // frame_count wrap from 65535 to 0.
    force s_dut.frame_count_reg = 16'hFFFF;
    #1;
    release s_dut.frame_count_reg;
    #1;
    check("fc_forced", 32'(s_fc), 65535);
    tick();
    n = 1;
    while (s_fs == 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check("fs_spacing2", 32'(n), 120);
    check("fc_wrap", 32'(s_fc), 0);
    tick();
    check("fs_one_cycle", 32'(s_fs), 0);
    check("fc_hold", 32'(s_fc), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
